vend_ctrl: RTL and testbench

//  Candy vending controller. Consumes the 3-bit command code produced by the keypad mapping stage.

---
 rtl/vend_ctrl.sv | 148 ++++++++++++++
 tb/tb_vend_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl.sv
// Candy vending controller: decodes edge-qualified keypad commands, keeps a
// saturating credit balance and generates fixed-length dispense / change strobes.
module vend_ctrl #(
    parameter int CREDIT_W    = 12,
    parameter int COIN_A_VAL  = 100,
    parameter int COIN_B_VAL  = 500,
    parameter int CANDY_PRICE = 300,
    parameter int CREDIT_MAX  = 2000,
    parameter int PULSE_CYC   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          key_code,
    output logic [CREDIT_W-1:0] credit,
    output logic                candy_out,
    output logic                change_out,
    output logic [CREDIT_W-1:0] change_val,
    output logic                coin_reject,
    output logic                no_funds,
    output logic                busy
);

    localparam int CNT_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

    localparam logic [CREDIT_W:0]   COIN_A_W = (CREDIT_W+1)'(COIN_A_VAL);
    localparam logic [CREDIT_W:0]   COIN_B_W = (CREDIT_W+1)'(COIN_B_VAL);
    localparam logic [CREDIT_W:0]   MAX_W    = (CREDIT_W+1)'(CREDIT_MAX);
    localparam logic [CREDIT_W-1:0] PRICE_W  = CREDIT_W'(CANDY_PRICE);
    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(PULSE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPENSE,
        S_CHANGE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          prev_q, prev_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_val_q, change_val_d;
    logic                candy_q, candy_d;
    logic                change_q, change_d;
    logic                reject_q, reject_d;
    logic                nofunds_q, nofunds_d;

    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   coin_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            prev_q       <= 3'b000;
            cnt_q        <= '0;
            credit_q     <= '0;
            change_val_q <= '0;
            candy_q      <= 1'b0;
            change_q     <= 1'b0;
            reject_q     <= 1'b0;
            nofunds_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            credit_q     <= credit_d;
            change_val_q <= change_val_d;
            candy_q      <= candy_d;
            change_q     <= change_d;
            reject_q     <= reject_d;
            nofunds_q    <= nofunds_d;
        end
    end

    // Sum is one bit wider than credit so the limit check cannot wrap.
    always_comb begin
        coin_val = (key_code == 3'b010) ? COIN_B_W : COIN_A_W;
        coin_sum = {1'b0, credit_q} + coin_val;
    end

    always_comb begin
        state_d      = state_q;
        prev_d       = key_code;
        cnt_d        = cnt_q;
        credit_d     = credit_q;
        change_val_d = change_val_q;
        candy_d      = candy_q;
        change_d     = change_q;
        reject_d     = 1'b0;
        nofunds_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Only a fresh press (previous cycle idle) is a command.
                if (prev_q == 3'b000) begin
                    case (key_code)
                        3'b001, 3'b010: begin
                            if (coin_sum <= MAX_W) begin
                                credit_d = coin_sum[CREDIT_W-1:0];
                            end else begin
                                reject_d = 1'b1;
                            end
                        end
                        3'b101: begin
                            if (credit_q >= PRICE_W) begin
                                credit_d = credit_q - PRICE_W;
                                candy_d  = 1'b1;
                                cnt_d    = CNT_LOAD;
                                state_d  = S_DISPENSE;
                            end else begin
                                nofunds_d = 1'b1;
                            end
                        end
                        3'b110: begin
                            if (credit_q != '0) begin
                                change_val_d = credit_q;
                                credit_d     = '0;
                                change_d     = 1'b1;
                                cnt_d        = CNT_LOAD;
                                state_d      = S_CHANGE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_DISPENSE, S_CHANGE: begin
                if (cnt_q == '0) begin
                    state_d      = S_IDLE;
                    candy_d      = 1'b0;
                    change_d     = 1'b0;
                    change_val_d = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign credit      = credit_q;
    assign candy_out   = candy_q;
    assign change_out  = change_q;
    assign change_val  = change_val_q;
    assign coin_reject = reject_q;
    assign no_funds    = nofunds_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed scenarios plus random key traffic,
// compared every cycle against a behavioural credit/strobe model.
module tb_vend_ctrl;

    localparam int CW    = 12;
    localparam int A     = 100;
    localparam int B     = 500;
    localparam int PRICE = 300;
    localparam int MAXC  = 2000;
    localparam int PULSE = 4;

    logic          clk;
    logic          rst_n;
    logic [2:0]    key_code;
    logic [CW-1:0] credit;
    logic          candy_out;
    logic          change_out;
    logic [CW-1:0] change_val;
    logic          coin_reject;
    logic          no_funds;
    logic          busy;

    int tests  = 0;
    int failed = 0;
    bit cmp_en = 0;

    // Behavioural model state: balance, remaining strobe cycles, pulses.
    int       m_credit = 0;
    int       m_left   = 0;
    int       m_val    = 0;
    bit       m_candy  = 0;
    bit       m_change = 0;
    bit       m_rej    = 0;
    bit       m_nf     = 0;
    int       m_prev   = 0;

    vend_ctrl #(
        .CREDIT_W(CW), .COIN_A_VAL(A), .COIN_B_VAL(B),
        .CANDY_PRICE(PRICE), .CREDIT_MAX(MAXC), .PULSE_CYC(PULSE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_code(key_code),
        .credit(credit), .candy_out(candy_out), .change_out(change_out),
        .change_val(change_val), .coin_reject(coin_reject),
        .no_funds(no_funds), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int k;
        if (!rst_n) begin
            m_credit = 0; m_left = 0; m_val = 0;
            m_candy = 0; m_change = 0; m_rej = 0; m_nf = 0; m_prev = 0;
        end else begin
            k = int'(key_code);
            m_rej = 0;
            m_nf  = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_candy = 0; m_change = 0; m_val = 0;
                end
            end else if (m_prev == 0) begin
                case (k)
                    1, 2: begin
                        if (m_credit + ((k == 1) ? A : B) <= MAXC)
                            m_credit += (k == 1) ? A : B;
                        else
                            m_rej = 1;
                    end
                    5: begin
                        if (m_credit >= PRICE) begin
                            m_credit -= PRICE; m_candy = 1; m_left = PULSE;
                        end else begin
                            m_nf = 1;
                        end
                    end
                    6: begin
                        if (m_credit > 0) begin
                            m_val = m_credit; m_credit = 0; m_change = 1; m_left = PULSE;
                        end
                    end
                    default: ;
                endcase
            end
            m_prev = k;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && cmp_en) begin
            chk("credit",      int'(credit),      m_credit);
            chk("candy_out",   int'(candy_out),   int'(m_candy));
            chk("change_out",  int'(change_out),  int'(m_change));
            chk("change_val",  int'(change_val),  m_val);
            chk("coin_reject", int'(coin_reject), int'(m_rej));
            chk("no_funds",    int'(no_funds),    int'(m_nf));
            chk("busy",        int'(busy),        int'(m_left > 0));
        end
    end

    task automatic press(input logic [2:0] c, input int hold);
        @(negedge clk) key_code = c;
        repeat (hold - 1) @(negedge clk);
        @(negedge clk) key_code = 3'b000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_high(input string nm, input int which, input int exp);
        int n = 0;
        for (int i = 0; i < 2 * PULSE + 2; i++) begin
            if (which == 0 ? candy_out : change_out) n++;
            @(negedge clk);
        end
        chk(nm, n, exp);
    endtask

    initial begin
        rst_n    = 0;
        key_code = 3'b000;
        idle(3);
        chk("rst_credit", int'(credit), 0);
        chk("rst_busy",   int'(busy), 0);
        chk("rst_candy",  int'(candy_out), 0);
        chk("rst_change", int'(change_out), 0);
        rst_n  = 1;
        cmp_en = 1;
        idle(2);

        // T1: three A coins, then a candy.
        press(3'b001, 1); chk("t1_c100", int'(credit), 100);
        press(3'b001, 1); chk("t1_c200", int'(credit), 200);
        press(3'b001, 1); chk("t1_c300", int'(credit), 300);
        press(3'b101, 1);
        chk("t1_credit0", int'(credit), 0);
        chk("t1_busy", int'(busy), 1);
        count_high("t1_candy_len", 0, PULSE);
        chk("t1_idle", int'(busy), 0);

        // T2: B coin, candy, then change of 200.
        press(3'b010, 1); chk("t2_c500", int'(credit), 500);
        press(3'b101, 1); chk("t2_c200", int'(credit), 200);
        idle(PULSE + 1);
        press(3'b110, 1);
        chk("t2_val", int'(change_val), 200);
        chk("t2_credit0", int'(credit), 0);
        count_high("t2_change_len", 1, PULSE);
        chk("t2_val_after", int'(change_val), 0);

        // T3: held key acts once; code-to-code change ignored; held candy dispenses once.
        press(3'b001, 10); chk("t3_hold", int'(credit), 100);
        @(negedge clk) key_code = 3'b001;
        @(negedge clk) key_code = 3'b010;
        @(negedge clk) key_code = 3'b010;
        @(negedge clk) key_code = 3'b000;
        chk("t3_nochain", int'(credit), 200);
        press(3'b010, 1); chk("t3_c700", int'(credit), 700);
        press(3'b101, 12);
        idle(PULSE + 2);
        chk("t3_one_disp", int'(credit), 400);

        // T4: upper credit limit.
        press(3'b110, 1); idle(PULSE + 1);
        repeat (3) press(3'b010, 1);
        repeat (3) press(3'b001, 1);
        chk("t4_c1800", int'(credit), 1800);
        press(3'b010, 1);
        chk("t4_reject", int'(coin_reject), 1);
        chk("t4_c1800b", int'(credit), 1800);
        idle(1);
        chk("t4_reject_1cyc", int'(coin_reject), 0);
        press(3'b001, 1); chk("t4_c1900", int'(credit), 1900);
        press(3'b001, 1); chk("t4_c2000", int'(credit), 2000);
        chk("t4_no_reject", int'(coin_reject), 0);

        // T5: insufficient funds, empty change, ignored codes.
        press(3'b110, 1); idle(PULSE + 1);
        press(3'b001, 1); press(3'b001, 1);
        press(3'b101, 1);
        chk("t5_nofunds", int'(no_funds), 1);
        chk("t5_nocandy", int'(candy_out), 0);
        press(3'b110, 1); idle(PULSE + 1);
        press(3'b110, 1);
        chk("t5_nochange", int'(change_out), 0);
        chk("t5_nobusy", int'(busy), 0);
        press(3'b011, 1); press(3'b100, 1); press(3'b111, 1);
        chk("t5_ignored", int'(credit), 0);

        // T6: asynchronous reset in the second DISPENSE cycle.
        repeat (3) press(3'b001, 1);
        press(3'b101, 1);
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        chk("t6_credit", int'(credit), 0);
        chk("t6_candy", int'(candy_out), 0);
        chk("t6_busy", int'(busy), 0);
        @(negedge clk) rst_n = 1;
        press(3'b001, 1);
        chk("t6_after", int'(credit), 100);

        // Random key traffic with occasional asynchronous resets.
        for (int it = 0; it < 500; it++) begin
            int hold;
            hold = $urandom_range(1, 4);
            @(negedge clk);
            key_code = ($urandom_range(0, 9) < 3) ? 3'b000 : 3'($urandom_range(0, 7));
            repeat (hold - 1) @(negedge clk);
            if ($urandom_range(0, 99) == 0) begin
                @(posedge clk); #2;
                rst_n = 0;
                #4;
                rst_n = 1;
            end
        end
        @(negedge clk) key_code = 3'b000;
        idle(PULSE + 2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
